fixed_vector_mac: RTL and testbench

//  Lane-parallel fixed-point multiply-accumulate. Each accepted beat computes IN_SIZE elementwise

---
 rtl/fixed_vector_mac.sv | 111 +++++++++++
 tb/tb_fixed_vector_mac.sv | 438 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fixed_vector_mac.sv
// Lane-parallel fixed-point multiply-accumulate: sums ACC_DEPTH beats of elementwise
// data_in*weight products per lane and emits one (optionally saturated) output vector per group.
module fixed_vector_mac #(
  parameter int IN_WIDTH     = 8,
  parameter int WEIGHT_WIDTH = 8,
  parameter int IN_SIZE      = 4,
  parameter int ACC_DEPTH    = 4,
  parameter int SIGNED       = 1,
  parameter int OUT_WIDTH    = IN_WIDTH + WEIGHT_WIDTH + $clog2(ACC_DEPTH)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [IN_SIZE*IN_WIDTH-1:0]     data_in,
  input  logic                            data_in_valid,
  output logic                            data_in_ready,
  input  logic [IN_SIZE*WEIGHT_WIDTH-1:0] weight,
  input  logic                            weight_valid,
  output logic                            weight_ready,
  output logic [IN_SIZE*OUT_WIDTH-1:0]    data_out,
  output logic                            data_out_valid,
  input  logic                            data_out_ready
);

  localparam int ACC_WIDTH = IN_WIDTH + WEIGHT_WIDTH + $clog2(ACC_DEPTH);
  localparam int CNT_WIDTH = (ACC_DEPTH > 1) ? $clog2(ACC_DEPTH) : 1;
  localparam logic [CNT_WIDTH-1:0] LAST_COUNT = CNT_WIDTH'(ACC_DEPTH - 1);

  logic [CNT_WIDTH-1:0] count;
  logic                 last;
  logic                 can_accept;
  logic                 fire;

  // Only the closing beat of a group needs the output register, so only it can stall.
  assign last          = (count == LAST_COUNT);
  assign can_accept    = rst & !(last & data_out_valid & !data_out_ready);
  assign data_in_ready = weight_valid & can_accept;
  assign weight_ready  = data_in_valid & can_accept;
  assign fire          = data_in_valid & weight_valid & can_accept;

  always_ff @(posedge clk) begin
    if (!rst) begin
      count          <= '0;
      data_out_valid <= 1'b0;
    end else begin
      if (fire) begin
        count <= last ? '0 : count + 1'b1;
      end
      if (fire && last) begin
        data_out_valid <= 1'b1;
      end else if (data_out_ready) begin
        data_out_valid <= 1'b0;
      end
    end
  end

  for (genvar i = 0; i < IN_SIZE; i++) begin : g_lane
    logic [IN_WIDTH-1:0]     d;
    logic [WEIGHT_WIDTH-1:0] w;
    logic [ACC_WIDTH-1:0]    d_ext;
    logic [ACC_WIDTH-1:0]    w_ext;
    logic [ACC_WIDTH-1:0]    product;
    logic [ACC_WIDTH-1:0]    sum;
    logic [ACC_WIDTH-1:0]    acc;
    logic [OUT_WIDTH-1:0]    sat;
    logic [OUT_WIDTH-1:0]    out_q;

    assign d = data_in[i*IN_WIDTH +: IN_WIDTH];
    assign w = weight[i*WEIGHT_WIDTH +: WEIGHT_WIDTH];

    if (SIGNED != 0) begin : g_sext
      assign d_ext = {{(ACC_WIDTH-IN_WIDTH){d[IN_WIDTH-1]}}, d};
      assign w_ext = {{(ACC_WIDTH-WEIGHT_WIDTH){w[WEIGHT_WIDTH-1]}}, w};
    end else begin : g_zext
      assign d_ext = {{(ACC_WIDTH-IN_WIDTH){1'b0}}, d};
      assign w_ext = {{(ACC_WIDTH-WEIGHT_WIDTH){1'b0}}, w};
    end

    // The low ACC_WIDTH bits of the product are exact for both signed and unsigned operands.
    assign product = d_ext * w_ext;
    assign sum     = acc + product;

    if (OUT_WIDTH == ACC_WIDTH) begin : g_pass
      assign sat = sum;
    end else if (SIGNED != 0) begin : g_sat_signed
      logic fits;
      assign fits = (sum[ACC_WIDTH-1:OUT_WIDTH-1] == '0) || (sum[ACC_WIDTH-1:OUT_WIDTH-1] == '1);
      assign sat  = fits ? sum[OUT_WIDTH-1:0]
                  : (sum[ACC_WIDTH-1] ? {1'b1, {(OUT_WIDTH-1){1'b0}}}
                                      : {1'b0, {(OUT_WIDTH-1){1'b1}}});
    end else begin : g_sat_unsigned
      assign sat = (|sum[ACC_WIDTH-1:OUT_WIDTH]) ? '1 : sum[OUT_WIDTH-1:0];
    end

    always_ff @(posedge clk) begin
      if (!rst) begin
        acc   <= '0;
        out_q <= '0;
      end else if (fire) begin
        if (last) begin
          acc   <= '0;
          out_q <= sat;
        end else begin
          acc <= sum;
        end
      end
    end

    assign data_out[i*OUT_WIDTH +: OUT_WIDTH] = out_q;
  end

endmodule

// File: tb/tb_fixed_vector_mac.sv
// Directed bench for fixed_vector_mac: default build plus saturating signed/unsigned
// builds and an ACC_DEPTH=1 build, all sharing one stimulus bus.
module tb_fixed_vector_mac;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] data_in;
  logic [31:0] weight;
  logic        data_in_valid;
  logic        weight_valid;
  logic        data_out_ready;

  logic        din_rdy, w_rdy, dout_v;
  logic [71:0] dout;
  logic        ss_din_rdy, ss_w_rdy, ss_v;
  logic [63:0] ss_dout;
  logic        su_din_rdy, su_w_rdy, su_v;
  logic [63:0] su_dout;
  logic        d1_din_rdy, d1_w_rdy, d1_v;
  logic [63:0] d1_dout;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  fixed_vector_mac dut (
    .clk(clk), .rst(rst),
    .data_in(data_in), .data_in_valid(data_in_valid), .data_in_ready(din_rdy),
    .weight(weight), .weight_valid(weight_valid), .weight_ready(w_rdy),
    .data_out(dout), .data_out_valid(dout_v), .data_out_ready(data_out_ready)
  );

  fixed_vector_mac #(.OUT_WIDTH(16)) dut_sat_s (
    .clk(clk), .rst(rst),
    .data_in(data_in), .data_in_valid(data_in_valid), .data_in_ready(ss_din_rdy),
    .weight(weight), .weight_valid(weight_valid), .weight_ready(ss_w_rdy),
    .data_out(ss_dout), .data_out_valid(ss_v), .data_out_ready(data_out_ready)
  );

  fixed_vector_mac #(.SIGNED(0), .OUT_WIDTH(16)) dut_sat_u (
    .clk(clk), .rst(rst),
    .data_in(data_in), .data_in_valid(data_in_valid), .data_in_ready(su_din_rdy),
    .weight(weight), .weight_valid(weight_valid), .weight_ready(su_w_rdy),
    .data_out(su_dout), .data_out_valid(su_v), .data_out_ready(data_out_ready)
  );

  fixed_vector_mac #(.ACC_DEPTH(1)) dut_d1 (
    .clk(clk), .rst(rst),
    .data_in(data_in), .data_in_valid(data_in_valid), .data_in_ready(d1_din_rdy),
    .weight(weight), .weight_valid(weight_valid), .weight_ready(d1_w_rdy),
    .data_out(d1_dout), .data_out_valid(d1_v), .data_out_ready(data_out_ready)
  );

  function automatic logic [31:0] rep8(input int v);
    logic [7:0] b;
    b = v[7:0];
    return {4{b}};
  endfunction

  function automatic logic [71:0] lanes18(input int v);
    logic [17:0] b;
    b = v[17:0];
    return {4{b}};
  endfunction

  function automatic logic [63:0] lanes16(input int v);
    logic [15:0] b;
    b = v[15:0];
    return {4{b}};
  endfunction

  task automatic do_reset();
    rst = 1'b0;
    data_in_valid = 1'b0;
    weight_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    data_in_valid = 1'b1;
    weight_valid = 1'b1;
    data_in = rep8(1);
    weight = rep8(1);
    data_out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      @(negedge clk);
      tests_run++;
      if ({din_rdy, w_rdy} !== 2'b00) begin
        tests_failed++;
        $display("[TB] FAIL reset_ready: got %b, expected 00", {din_rdy, w_rdy});
      end
      tests_run++;
      if (dout_v !== 1'b0) begin
        tests_failed++;
        $display("[TB] FAIL reset_valid: got %b, expected 0", dout_v);
      end
      tests_run++;
      if (dout !== 72'd0) begin
        tests_failed++;
        $display("[TB] FAIL reset_data: got %h, expected 0", dout);
      end
    end
    rst = 1'b1;
    #1;
    tests_run++;
    if ({din_rdy, w_rdy} !== 2'b11) begin
      tests_failed++;
      $display("[TB] FAIL release_ready: got %b, expected 11", {din_rdy, w_rdy});
    end
    repeat (4) @(posedge clk);
    @(negedge clk);
    tests_run++;
    if (dout_v !== 1'b1 || dout !== lanes18(4)) begin
      tests_failed++;
      $display("[TB] FAIL release_first_group: got v=%b %h, expected v=1 %h", dout_v, dout, lanes18(4));
    end
    data_in_valid = 1'b0;
    weight_valid = 1'b0;
  endtask

  task automatic test_accumulate();
    do_reset();
    data_out_ready = 1'b1;
    data_in = rep8(3);
    weight = rep8(-2);
    data_in_valid = 1'b1;
    weight_valid = 1'b1;
    for (int b = 1; b <= 4; b++) begin
      #1;
      tests_run++;
      if ({din_rdy, w_rdy} !== 2'b11) begin
        tests_failed++;
        $display("[TB] FAIL acc_ready beat %0d: got %b, expected 11", b, {din_rdy, w_rdy});
      end
      @(posedge clk);
      @(negedge clk);
      if (b < 4) begin
        tests_run++;
        if (dout_v !== 1'b0) begin
          tests_failed++;
          $display("[TB] FAIL acc_early_valid beat %0d: got %b, expected 0", b, dout_v);
        end
      end
    end
    tests_run++;
    if (dout_v !== 1'b1 || dout !== lanes18(-24)) begin
      tests_failed++;
      $display("[TB] FAIL acc_result: got v=%b %h, expected v=1 %h", dout_v, dout, lanes18(-24));
    end
    data_in_valid = 1'b0;
    weight_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    tests_run++;
    if (dout_v !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL acc_valid_pulse: got %b, expected 0", dout_v);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    data_out_ready = 1'b0;
    data_in = rep8(2);
    weight = rep8(1);
    data_in_valid = 1'b1;
    weight_valid = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    tests_run++;
    if (dout_v !== 1'b1 || dout !== lanes18(8)) begin
      tests_failed++;
      $display("[TB] FAIL bp_first: got v=%b %h, expected v=1 %h", dout_v, dout, lanes18(8));
    end
    data_in = rep8(1);
    for (int b = 1; b <= 3; b++) begin
      #1;
      tests_run++;
      if ({din_rdy, w_rdy} !== 2'b11) begin
        tests_failed++;
        $display("[TB] FAIL bp_accept beat %0d: got %b, expected 11", b, {din_rdy, w_rdy});
      end
      @(posedge clk);
      @(negedge clk);
      tests_run++;
      if (dout_v !== 1'b1 || dout !== lanes18(8)) begin
        tests_failed++;
        $display("[TB] FAIL bp_hold beat %0d: got v=%b %h, expected v=1 %h", b, dout_v, dout, lanes18(8));
      end
    end
    for (int c = 0; c < 2; c++) begin
      #1;
      tests_run++;
      if ({din_rdy, w_rdy} !== 2'b00) begin
        tests_failed++;
        $display("[TB] FAIL bp_stall: got %b, expected 00", {din_rdy, w_rdy});
      end
      @(posedge clk);
      @(negedge clk);
      tests_run++;
      if (dout_v !== 1'b1 || dout !== lanes18(8)) begin
        tests_failed++;
        $display("[TB] FAIL bp_stall_hold: got v=%b %h, expected v=1 %h", dout_v, dout, lanes18(8));
      end
    end
    data_out_ready = 1'b1;
    #1;
    tests_run++;
    if ({din_rdy, w_rdy} !== 2'b11) begin
      tests_failed++;
      $display("[TB] FAIL bp_release: got %b, expected 11", {din_rdy, w_rdy});
    end
    @(posedge clk);
    @(negedge clk);
    tests_run++;
    if (dout_v !== 1'b1 || dout !== lanes18(4)) begin
      tests_failed++;
      $display("[TB] FAIL bp_new: got v=%b %h, expected v=1 %h", dout_v, dout, lanes18(4));
    end
    data_in_valid = 1'b0;
    weight_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    tests_run++;
    if (dout_v !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL bp_drain: got %b, expected 0", dout_v);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    data_out_ready = 1'b1;
    data_in_valid = 1'b1;
    weight_valid = 1'b1;
    data_in = rep8(127);
    weight = rep8(127);
    repeat (4) @(posedge clk);
    @(negedge clk);
    tests_run++;
    if (ss_dout !== lanes16(32767)) begin
      tests_failed++;
      $display("[TB] FAIL sat_pos: got %h, expected %h", ss_dout, lanes16(32767));
    end
    tests_run++;
    if (dout !== lanes18(64516)) begin
      tests_failed++;
      $display("[TB] FAIL full_width_pos: got %h, expected %h", dout, lanes18(64516));
    end
    tests_run++;
    if (su_dout !== lanes16(64516)) begin
      tests_failed++;
      $display("[TB] FAIL unsigned_in_range: got %h, expected %h", su_dout, lanes16(64516));
    end
    data_in = rep8(-128);
    repeat (4) @(posedge clk);
    @(negedge clk);
    tests_run++;
    if (ss_dout !== lanes16(-32768)) begin
      tests_failed++;
      $display("[TB] FAIL sat_neg: got %h, expected %h", ss_dout, lanes16(-32768));
    end
    tests_run++;
    if (dout !== lanes18(-65024)) begin
      tests_failed++;
      $display("[TB] FAIL full_width_neg: got %h, expected %h", dout, lanes18(-65024));
    end
    data_in = rep8(255);
    weight = rep8(255);
    repeat (4) @(posedge clk);
    @(negedge clk);
    tests_run++;
    if (su_dout !== lanes16(65535)) begin
      tests_failed++;
      $display("[TB] FAIL sat_unsigned: got %h, expected %h", su_dout, lanes16(65535));
    end
    tests_run++;
    if (ss_dout !== lanes16(4) || dout !== lanes18(4)) begin
      tests_failed++;
      $display("[TB] FAIL signed_minus_one: got %h / %h, expected %h / %h", ss_dout, dout, lanes16(4), lanes18(4));
    end
    data_in_valid = 1'b0;
    weight_valid = 1'b0;
  endtask

  task automatic test_one_sided();
    do_reset();
    data_out_ready = 1'b1;
    data_in = rep8(7);
    weight = rep8(1);
    data_in_valid = 1'b1;
    weight_valid = 1'b0;
    for (int c = 0; c < 5; c++) begin
      #1;
      tests_run++;
      if ({din_rdy, w_rdy} !== 2'b01) begin
        tests_failed++;
        $display("[TB] FAIL one_sided_ready: got %b, expected 01", {din_rdy, w_rdy});
      end
      @(posedge clk);
      @(negedge clk);
      tests_run++;
      if (dout_v !== 1'b0) begin
        tests_failed++;
        $display("[TB] FAIL one_sided_no_output: got %b, expected 0", dout_v);
      end
    end
    data_in = rep8(1);
    weight_valid = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    tests_run++;
    if (dout_v !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL one_sided_count: got %b, expected 0", dout_v);
    end
    @(posedge clk);
    @(negedge clk);
    tests_run++;
    if (dout_v !== 1'b1 || dout !== lanes18(4)) begin
      tests_failed++;
      $display("[TB] FAIL one_sided_group: got v=%b %h, expected v=1 %h", dout_v, dout, lanes18(4));
    end
    data_in_valid = 1'b0;
    weight_valid = 1'b0;
  endtask

  task automatic test_mid_reset();
    do_reset();
    data_out_ready = 1'b1;
    data_in = rep8(5);
    weight = rep8(5);
    data_in_valid = 1'b1;
    weight_valid = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    data_in = rep8(1);
    weight = rep8(1);
    for (int b = 1; b <= 3; b++) begin
      @(posedge clk);
      @(negedge clk);
      tests_run++;
      if (dout_v !== 1'b0) begin
        tests_failed++;
        $display("[TB] FAIL mid_reset_early beat %0d: got %b, expected 0", b, dout_v);
      end
    end
    @(posedge clk);
    @(negedge clk);
    tests_run++;
    if (dout_v !== 1'b1 || dout !== lanes18(4)) begin
      tests_failed++;
      $display("[TB] FAIL mid_reset_result: got v=%b %h, expected v=1 %h", dout_v, dout, lanes18(4));
    end
    data_in_valid = 1'b0;
    weight_valid = 1'b0;
  endtask

  task automatic test_back_to_back();
    do_reset();
    data_out_ready = 1'b1;
    weight = rep8(2);
    data_in_valid = 1'b1;
    weight_valid = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      data_in = rep8(k);
      #1;
      tests_run++;
      if ({d1_din_rdy, d1_w_rdy} !== 2'b11) begin
        tests_failed++;
        $display("[TB] FAIL d1_ready beat %0d: got %b, expected 11", k, {d1_din_rdy, d1_w_rdy});
      end
      @(posedge clk);
      @(negedge clk);
      tests_run++;
      if (d1_v !== 1'b1 || d1_dout !== lanes16(2 * k)) begin
        tests_failed++;
        $display("[TB] FAIL d1_result beat %0d: got v=%b %h, expected v=1 %h", k, d1_v, d1_dout, lanes16(2 * k));
      end
    end
    tests_run++;
    if (dout_v !== 1'b1 || dout !== lanes18(20)) begin
      tests_failed++;
      $display("[TB] FAIL b2b_group: got v=%b %h, expected v=1 %h", dout_v, dout, lanes18(20));
    end
    data_out_ready = 1'b0;
    data_in = rep8(1);
    #1;
    tests_run++;
    if ({d1_din_rdy, d1_w_rdy} !== 2'b00) begin
      tests_failed++;
      $display("[TB] FAIL d1_stall: got %b, expected 00", {d1_din_rdy, d1_w_rdy});
    end
    tests_run++;
    if ({din_rdy, w_rdy} !== 2'b11) begin
      tests_failed++;
      $display("[TB] FAIL nonlast_no_stall: got %b, expected 11", {din_rdy, w_rdy});
    end
    @(posedge clk);
    @(negedge clk);
    tests_run++;
    if (d1_v !== 1'b1 || d1_dout !== lanes16(8)) begin
      tests_failed++;
      $display("[TB] FAIL d1_hold: got v=%b %h, expected v=1 %h", d1_v, d1_dout, lanes16(8));
    end
    data_in_valid = 1'b0;
    weight_valid = 1'b0;
    data_out_ready = 1'b1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_accumulate();
    test_backpressure();
    test_saturation();
    test_one_sided();
    test_mid_reset();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
